// File: rtl/loadable_counter_pkg.sv
// Shared definitions for the loadable counter slice.
//
// Contents:
//   LC_DEFAULT_WIDTH  default counter width (8)
//   lc_all_ones()     all-ones value for a width of 1..32 bits, returned
//                     right-aligned in a 32-bit word
package loadable_counter_pkg;

  localparam int LC_DEFAULT_WIDTH = 8;

  // Evaluated at elaboration time to size terminal-count constants. The
  // 32-bit case is handled separately because 1 << 32 overflows the word.
  function automatic logic [31:0] lc_all_ones(input int unsigned width);
    if (width >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage : loadable_counter_pkg

// File: rtl/loadable_counter_if.sv
// Bundle of the counter control inputs and count outputs.
//
// Signals:
//   ld           synchronous load strobe
//   en           synchronous count enable
//   input_value  value loaded when ld=1 (WIDTH bits)
//   counter      registered count (WIDTH bits)
//   tc           terminal count, combinational
//
// Modports:
//   master  drives ld/en/input_value, observes counter/tc
//   slave   the counter itself
interface loadable_counter_if
  import loadable_counter_pkg::*;
#(
  parameter int WIDTH = LC_DEFAULT_WIDTH
);

  logic             ld;
  logic             en;
  logic [WIDTH-1:0] input_value;
  logic [WIDTH-1:0] counter;
  logic             tc;

  modport master (
    output ld,
    output en,
    output input_value,
    input  counter,
    input  tc
  );

  modport slave (
    input  ld,
    input  en,
    input  input_value,
    output counter,
    output tc
  );

endinterface : loadable_counter_if

// File: rtl/loadable_counter_next.sv
// Combinational next-state and terminal-count logic for loadable_counter.
//
// Priority: ld > en > hold. With LOADABLE_COUNTER_SAT_EN defined the count
// saturates at all-ones instead of wrapping to zero; load always wins.
//
// Ports:
//   counter       current registered count
//   ld            load strobe
//   en            count enable
//   input_value   value to load
//   counter_next  value for the next rising edge
//   tc            1 when counter is all-ones, en=1 and ld=0
module loadable_counter_next
  import loadable_counter_pkg::*;
#(
  parameter int WIDTH = LC_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] counter,
  input  logic             ld,
  input  logic             en,
  input  logic [WIDTH-1:0] input_value,
  output logic [WIDTH-1:0] counter_next,
  output logic             tc
);

  localparam logic [31:0]      ONES_WORD = lc_all_ones(WIDTH);
  localparam logic [WIDTH-1:0] MAX_COUNT = ONES_WORD[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic at_max;

  assign at_max = (counter == MAX_COUNT);

  always_comb begin
    // NOTE: default first so every path assigns counter_next; otherwise the
    // hold case would infer a latch instead of plain feedback.
    counter_next = counter;
    if (ld) begin
      counter_next = input_value;
    end else if (en) begin
`ifdef LOADABLE_COUNTER_SAT_EN
      if (!at_max) begin
        counter_next = counter + ONE;
      end
`else
      // Unsized-free add truncates to WIDTH, so all-ones wraps to zero.
      counter_next = counter + ONE;
`endif
    end
  end

  // Same condition in both modes: in wrap mode it flags the imminent wrap,
  // in saturate mode it stays high while pinned at all-ones.
  assign tc = at_max & en & ~ld;

endmodule : loadable_counter_next

// File: rtl/loadable_counter.sv
// Synchronous up-counter with parallel load, count enable and asynchronous
// active-low reset.
//
// Configuration macro: LOADABLE_COUNTER_SAT_EN
//   defined   -> count saturates at all-ones
//   undefined -> count wraps modulo 2^WIDTH (default)
//
// Parameters:
//   WIDTH  counter width, 2..32 (default LC_DEFAULT_WIDTH = 8)
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active low; clears counter immediately
//   bus   loadable_counter_if.slave (ld, en, input_value, counter, tc)
module loadable_counter
  import loadable_counter_pkg::*;
#(
  parameter int WIDTH = LC_DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  loadable_counter_if.slave bus
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  loadable_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .counter      (count_q),
    .ld           (bus.ld),
    .en           (bus.en),
    .input_value  (bus.input_value),
    .counter_next (count_d),
    .tc           (bus.tc)
  );

  // Asynchronous clear wins over any load/enable presented in the same cycle,
  // so nothing pending survives a reset pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignment for registered state so every flop
      // samples values from before the edge, independent of block ordering.
      count_q <= count_d;
    end
  end

  assign bus.counter = count_q;

endmodule : loadable_counter

// File: tb/tb_loadable_counter.sv
// Scoreboard bench for loadable_counter (WIDTH = 8).
// The stimulus process drives one vector per cycle and queues the counter/tc
// expected after the next rising edge; the monitor pops and compares on each
// falling edge, or immediately when an asynchronous event is flagged.
// Expected values are written by hand; the wrap/saturate step follows
// LOADABLE_COUNTER_SAT_EN.
module tb_loadable_counter;

  typedef struct {
    logic [7:0] cnt;
    logic       tc;
    string      name;
  } exp_t;

  logic clk;
  logic rst;

  exp_t sb[$];
  event sample_ev;
  int   checks;
  int   errors;

  loadable_counter_if #(.WIDTH(8)) bus ();

  loadable_counter #(
    .WIDTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LOADABLE_COUNTER_SAT_EN
  localparam logic [7:0] WRAP_CNT = 8'hFF;
  localparam logic       WRAP_TC  = 1'b1;
`else
  localparam logic [7:0] WRAP_CNT = 8'h00;
  localparam logic       WRAP_TC  = 1'b0;
`endif

  task automatic push_exp(input logic [7:0] c, input logic t, input string nm);
    exp_t e;
    e.cnt  = c;
    e.tc   = t;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Drive one vector just after a falling edge; the result is checked at the
  // following falling edge, after one rising edge has applied it.
  task automatic step(input logic r, input logic l, input logic e,
                      input logic [7:0] v, input logic [7:0] ec,
                      input logic et, input string nm);
    @(negedge clk);
    #1;
    rst             = r;
    bus.ld          = l;
    bus.en          = e;
    bus.input_value = v;
    push_exp(ec, et, nm);
  endtask

  // Monitor: compares the oldest expectation whenever the DUT output is due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.counter !== e.cnt || bus.tc !== e.tc) begin
          errors++;
          $display("FAIL %s: counter=%h tc=%b, expected counter=%h tc=%b",
                   e.name, bus.counter, bus.tc, e.cnt, e.tc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b0;
    bus.ld          = 1'b0;
    bus.en          = 1'b0;
    bus.input_value = 8'h01;

    // Reset asserted before any clock edge: counter must already be 0.
    #3;
    push_exp(8'h00, 1'b0, "rst_async");
    -> sample_ev;

    // Load/enable ignored while reset is held.
    step(1'b0, 1'b1, 1'b1, 8'h55, 8'h00, 1'b0, "rst_hold");
    step(1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, "rel_hold");

    // Load held for two edges, then hold; input_value ignored without ld.
    step(1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0, "load1");
    step(1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0, "load1_again");
    step(1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, "hold1");
    step(1'b1, 1'b0, 1'b0, 8'h77, 8'h01, 1'b0, "iv_ignored");

    // Count 2..6 then hold.
    step(1'b1, 1'b0, 1'b1, 8'h77, 8'h02, 1'b0, "cnt2");
    step(1'b1, 1'b0, 1'b1, 8'h77, 8'h03, 1'b0, "cnt3");
    step(1'b1, 1'b0, 1'b1, 8'h77, 8'h04, 1'b0, "cnt4");
    step(1'b1, 1'b0, 1'b1, 8'h77, 8'h05, 1'b0, "cnt5");
    step(1'b1, 1'b0, 1'b1, 8'h77, 8'h06, 1'b0, "cnt6");
    step(1'b1, 1'b0, 1'b0, 8'h77, 8'h06, 1'b0, "hold6");

    // Load beats enable.
    step(1'b1, 1'b1, 1'b1, 8'h40, 8'h40, 1'b0, "prio_load");
    step(1'b1, 1'b0, 1'b1, 8'h40, 8'h41, 1'b0, "after_prio");

    // Terminal count and wrap (or saturate).
    step(1'b1, 1'b1, 1'b0, 8'hFE, 8'hFE, 1'b0, "load_fe");
    step(1'b1, 1'b0, 1'b1, 8'hFE, 8'hFF, 1'b1, "reach_ff");
    step(1'b1, 1'b0, 1'b1, 8'hFE, WRAP_CNT, WRAP_TC, "wrap");

    // tc suppressed by ld even at all-ones with en=1.
    step(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, "tc_ld_block");
    step(1'b1, 1'b0, 1'b1, 8'hFF, WRAP_CNT, WRAP_TC, "wrap2");

    // Asynchronous reset between edges while counting from 0x23.
    step(1'b1, 1'b1, 1'b0, 8'h23, 8'h23, 1'b0, "load23");
    @(negedge clk);
    #2;
    bus.ld = 1'b0;
    bus.en = 1'b1;
    rst    = 1'b0;
    #1;
    push_exp(8'h00, 1'b0, "rst_mid");
    -> sample_ev;
    #1;
    rst = 1'b1;
    push_exp(8'h01, 1'b0, "post_rst1");
    step(1'b1, 1'b0, 1'b1, 8'h23, 8'h02, 1'b0, "post_rst2");
    step(1'b1, 1'b0, 1'b1, 8'h23, 8'h03, 1'b0, "post_rst3");

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_loadable_counter

// File: doc/loadable_counter.md
Name: loadable_counter

Overview:
- Synchronous up-counter with parallel load, count enable and asynchronous active-low reset.
- General-purpose building block for timers, address generators and preset-able event counters inside datapath/control logic.
- Single clock domain; all state updates on rising edge of clk except reset.

Parameters:
- WIDTH, 8, bit width of input_value and counter (legal range 2..32).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
- ld  input  1  synchronous load strobe; loads input_value into counter.
- en  input  1  synchronous count enable; increments counter by 1.
- input_value  input  WIDTH  value loaded when ld=1.
- counter  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: 1 when counter == all-ones and en=1 and ld=0.

Behaviour:
- Reset: rst=0 forces counter to 0 immediately, with no clock edge needed; held at 0 while rst=0. tc=0 during reset.
- Reset release: first rising edge with rst=1 applies the normal rules below. No extra latency.
- Priority at each rising edge (rst=1): ld > en > hold.
  - ld=1: counter <= input_value. This applies regardless of en.
  - ld=0, en=1: counter <= counter + 1, modulo 2^WIDTH. All-ones wraps to 0.
  - ld=0, en=0: counter holds.
- Latency: load and increment are visible on counter one cycle after the sampling edge.
- ld held high for several cycles: counter re-loads each edge, so it stays at input_value. Counting resumes on the first edge with ld=0 and en=1.
- input_value changes while ld=0: no effect on counter.
- Reset mid-operation: asynchronous clear overrides any ld/en in flight. No pending load survives reset.
- tc pulse: asserted in the cycle where the next edge will wrap all-ones to 0. Deasserted when ld=1.
- X-safety: counter never goes X after reset, given known ld/en.

Optional Feature:
- Macro: LOADABLE_COUNTER_SAT_EN.
- Defined: counter saturates at all-ones. en=1 at all-ones holds the value, and tc stays high while counter == all-ones and en=1 and ld=0. Load still overrides saturation.
- Undefined: modulo wrap-around as specified above.

Decomposition:
- Shared package loadable_counter_pkg:
  - constant LC_DEFAULT_WIDTH = 8.
  - function returning the all-ones value for a given width.
- One natural sub-module: loadable_counter_next.
  - Purely combinational next-state and tc computation from counter, ld, en and input_value, including the saturate/wrap selection.
  - Top level holds only the register and asynchronous reset.

Test Plan:
- Reset: rst=0 with ld=0, en=0, input_value=1 -> counter=0 immediately, including mid-cycle. Release rst=1 with en=0 -> counter stays 0.
- Load: rst=1, ld=1 for 2 edges, input_value=1 -> counter=1 after the first edge and stays 1. Drop ld with en=0 -> counter holds 1.
- Count: from counter=1, en=1 for 5 edges -> counter=2,3,4,5,6. Drop en -> counter holds 6.
- Priority: ld=1 and en=1 together, input_value=8'h40 -> counter=8'h40, not 8'h41. Next edge with ld=0, en=1 -> counter=8'h41.
- Wrap and tc: load 8'hFE, then en=1 -> counter 8'hFF with tc=1, next edge counter 8'h00 and tc=0. With LOADABLE_COUNTER_SAT_EN -> counter stays 8'hFF.
- Asynchronous reset mid-count: en=1 with counter=8'h23, pulse rst=0 between edges -> counter=0 at once. After release it counts 1,2,...
